battle_sequencer: RTL and testbench

//  Top-level turn controller for the battle screen. Drives the 4-bit state
//  bus that the player-attack stage and the enemy-attack stage decode.

---
 rtl/battle_sequencer.sv | 178 +++++++++++++++++
 tb/tb_battle_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/battle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : battle_sequencer
//  Description : Turn controller for the battle screen. It drives the 4-bit
//                state bus that is decoded by the player-attack and
//                enemy-attack stages. The turn order is player -> gap ->
//                enemy -> gap -> player. The battle ends in WIN when the
//                enemy HP is zero, or in LOSE when the soul HP is zero. Gaps
//                between turns are timed in frames, and a per-turn watchdog
//                forces the battle forward when a turn runs too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module battle_sequencer #(
  parameter int GAP_FRAMES     = 30,
  parameter int TIMEOUT_FRAMES = 1800
) (
  input  logic        clk,
  input  logic        rst,                 // asynchronous, active-low
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_in,
  input  logic        player_finished_in,
  input  logic        enemy_finished_in,
  input  logic [10:0] enemy_hp_in,
  input  logic [7:0]  soul_hp_in,
  output logic [3:0]  state_out,
  output logic        phase_start_out,
  output logic [7:0]  turn_count_out,
  output logic        timeout_out
);

  typedef enum logic [3:0] {
    S_TITLE  = 4'b0000,
    S_PLAYER = 4'b0001,
    S_ENEMY  = 4'b0010,
    S_GAP_PE = 4'b0100,
    S_GAP_EP = 4'b0101,
    S_WIN    = 4'b1000,
    S_LOSE   = 4'b1001
  } state_t;

  localparam logic [10:0] C_GAP_LAST     = 11'(GAP_FRAMES - 1);
  localparam logic [10:0] C_GAP          = 11'(GAP_FRAMES);
  localparam logic [10:0] C_TIMEOUT_LAST = 11'(TIMEOUT_FRAMES - 1);
  localparam logic [10:0] C_CNT_MAX      = 11'h7FF;
  localparam logic [7:0]  C_TURN_MAX     = 8'hFF;

  state_t      r_state;
  state_t      w_next;
  logic [10:0] r_frame_cnt;
  logic [7:0]  r_turn_cnt;
  logic        r_timeout;
  logic        r_phase_start;
  logic        w_tick;
  logic        w_soul_dead;
  logic        w_set_timeout;
  logic        w_first_turn;
  logic        w_next_turn;
  logic        w_watchdog;
  logic        w_gap_done;

  assign w_tick      = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_soul_dead = (soul_hp_in == 8'd0);
  // The watchdog fires on the TIMEOUT_FRAMES-th frame tick spent in a turn.
  assign w_watchdog  = w_tick && (r_frame_cnt == C_TIMEOUT_LAST);
  // A gap ends on its GAP_FRAMES-th frame tick.
  assign w_gap_done  = w_tick && (r_frame_cnt == C_GAP_LAST);

  // Next-state decode and the side-effect strobes for the counters.
  always_comb begin
    w_next        = r_state;
    w_set_timeout = 1'b0;
    w_first_turn  = 1'b0;
    w_next_turn   = 1'b0;
    unique case (r_state)
      S_TITLE: begin
        if (start_in) begin
          w_next       = S_PLAYER;
          w_first_turn = 1'b1;
        end
      end
      S_PLAYER: begin
        if (w_soul_dead) begin
          w_next = S_LOSE;
        end else if (player_finished_in) begin
          w_next = S_GAP_PE;
        end else if (w_watchdog) begin
          w_next        = S_GAP_PE;
          w_set_timeout = 1'b1;
        end
      end
      S_GAP_PE: begin
        if (w_soul_dead) begin
          w_next = S_LOSE;
        end else if (w_gap_done) begin
          w_next = (enemy_hp_in == 11'd0) ? S_WIN : S_ENEMY;
        end
      end
      S_ENEMY: begin
        // A dead soul outranks a finished enemy stage and the watchdog.
        if (w_soul_dead) begin
          w_next = S_LOSE;
        end else if (enemy_finished_in) begin
          w_next = S_GAP_EP;
        end else if (w_watchdog) begin
          w_next        = S_GAP_EP;
          w_set_timeout = 1'b1;
        end
      end
      S_GAP_EP: begin
        if (w_soul_dead) begin
          w_next = S_LOSE;
        end else if (w_gap_done) begin
          w_next      = S_PLAYER;
          w_next_turn = 1'b1;
        end
      end
      S_WIN, S_LOSE: begin
        // A start pulse that comes before the hold time is simply lost.
        if (start_in && (r_frame_cnt >= C_GAP)) begin
          w_next = S_TITLE;
        end
      end
      default: w_next = S_TITLE;
    endcase
  end

  // State register and the one-cycle pulse that marks each new state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_TITLE;
      r_phase_start <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_phase_start <= (w_next != r_state);
    end
  end

  // Frame counter. It restarts on every state change and saturates at its maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= 11'd0;
    end else if (w_next != r_state) begin
      r_frame_cnt <= 11'd0;
    end else if (w_tick && (r_frame_cnt != C_CNT_MAX)) begin
      r_frame_cnt <= r_frame_cnt + 11'd1;
    end
  end

  // Turn counter. It becomes 1 on leaving TITLE and saturates at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_turn_cnt <= 8'd0;
    end else if (w_first_turn) begin
      r_turn_cnt <= 8'd1;
    end else if (w_next_turn && (r_turn_cnt != C_TURN_MAX)) begin
      r_turn_cnt <= r_turn_cnt + 8'd1;
    end
  end

  // Sticky watchdog flag. It is cleared only when a new battle starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout <= 1'b0;
    end else if (w_first_turn) begin
      r_timeout <= 1'b0;
    end else if (w_set_timeout) begin
      r_timeout <= 1'b1;
    end
  end

  assign state_out       = r_state;
  assign phase_start_out = r_phase_start;
  assign turn_count_out  = r_turn_cnt;
  assign timeout_out     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_battle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_battle_sequencer
//  Description : Directed self-checking bench for battle_sequencer
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_battle_sequencer;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        start_in;
  logic        player_finished_in;
  logic        enemy_finished_in;
  logic [10:0] enemy_hp_in;
  logic [7:0]  soul_hp_in;
  logic [3:0]  state_out;
  logic        phase_start_out;
  logic [7:0]  turn_count_out;
  logic        timeout_out;

  int checks;
  int failures;

  localparam logic [3:0] C_TITLE  = 4'b0000;
  localparam logic [3:0] C_PLAYER = 4'b0001;
  localparam logic [3:0] C_ENEMY  = 4'b0010;
  localparam logic [3:0] C_GAP_PE = 4'b0100;
  localparam logic [3:0] C_GAP_EP = 4'b0101;
  localparam logic [3:0] C_WIN    = 4'b1000;
  localparam logic [3:0] C_LOSE   = 4'b1001;

  battle_sequencer #(
    .GAP_FRAMES     (30),
    .TIMEOUT_FRAMES (1800)
  ) u_dut (
    .clk                (clk),
    .rst                (rst),
    .hcount_in          (hcount_in),
    .vcount_in          (vcount_in),
    .start_in           (start_in),
    .player_finished_in (player_finished_in),
    .enemy_finished_in  (enemy_finished_in),
    .enemy_hp_in        (enemy_hp_in),
    .soul_hp_in         (soul_hp_in),
    .state_out          (state_out),
    .phase_start_out    (phase_start_out),
    .turn_count_out     (turn_count_out),
    .timeout_out        (timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each frame tick lasts one cycle and is followed by one idle cycle.
  task automatic frame_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      hcount_in = 11'd0;
      vcount_in = 10'd0;
      step();
      hcount_in = 11'd5;
      vcount_in = 10'd3;
      step();
    end
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
  endtask

  task automatic finish_player();
    player_finished_in = 1'b1;
    step();
    player_finished_in = 1'b0;
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst                = 1'b0;
    hcount_in          = 11'd5;
    vcount_in          = 10'd3;
    start_in           = 1'b0;
    player_finished_in = 1'b0;
    enemy_finished_in  = 1'b0;
    enemy_hp_in        = 11'd50;
    soul_hp_in         = 8'd100;
    repeat (3) step();
    check_eq("rst_state", 32'(state_out), 32'(C_TITLE));
    check_eq("rst_phase", 32'(phase_start_out), 32'd0);
    check_eq("rst_turn", 32'(turn_count_out), 32'd0);
    check_eq("rst_timeout", 32'(timeout_out), 32'd0);
    rst = 1'b1;
    step();
    check_eq("title_hold", 32'(state_out), 32'(C_TITLE));
    check_eq("title_hold_phase", 32'(phase_start_out), 32'd0);

    // Test 1: start pulse enters PLAYER.
    pulse_start();
    check_eq("t1_state", 32'(state_out), 32'(C_PLAYER));
    check_eq("t1_phase", 32'(phase_start_out), 32'd1);
    check_eq("t1_turn", 32'(turn_count_out), 32'd1);
    step();
    check_eq("t1_phase_drop", 32'(phase_start_out), 32'd0);
    check_eq("t1_still_player", 32'(state_out), 32'(C_PLAYER));

    // Test 2: one full round, then back to PLAYER.
    finish_player();
    check_eq("t2_gap_pe", 32'(state_out), 32'(C_GAP_PE));
    check_eq("t2_gap_pe_phase", 32'(phase_start_out), 32'd1);
    frame_ticks(29);
    check_eq("t2_gap_pe_29", 32'(state_out), 32'(C_GAP_PE));
    frame_ticks(1);
    check_eq("t2_enemy", 32'(state_out), 32'(C_ENEMY));
    enemy_finished_in = 1'b1;
    step();
    enemy_finished_in = 1'b0;
    check_eq("t2_gap_ep", 32'(state_out), 32'(C_GAP_EP));
    frame_ticks(29);
    check_eq("t2_gap_ep_29", 32'(state_out), 32'(C_GAP_EP));
    frame_ticks(1);
    check_eq("t2_player2", 32'(state_out), 32'(C_PLAYER));
    check_eq("t2_turn2", 32'(turn_count_out), 32'd2);

    // Test 3: a dead enemy ends in WIN, and the early start is dropped.
    enemy_hp_in = 11'd0;
    finish_player();
    frame_ticks(30);
    check_eq("t3_win", 32'(state_out), 32'(C_WIN));
    frame_ticks(10);
    pulse_start();
    check_eq("t3_early_start", 32'(state_out), 32'(C_WIN));
    step();
    check_eq("t3_not_queued", 32'(state_out), 32'(C_WIN));
    frame_ticks(21);
    pulse_start();
    check_eq("t3_title", 32'(state_out), 32'(C_TITLE));
    check_eq("t3_title_phase", 32'(phase_start_out), 32'd1);

    // Test 4: a dead soul outranks enemy_finished in ENEMY.
    enemy_hp_in = 11'd50;
    pulse_start();
    check_eq("t4_turn_reset", 32'(turn_count_out), 32'd1);
    finish_player();
    frame_ticks(30);
    check_eq("t4_enemy", 32'(state_out), 32'(C_ENEMY));
    soul_hp_in        = 8'd0;
    enemy_finished_in = 1'b1;
    step();
    enemy_finished_in = 1'b0;
    soul_hp_in        = 8'd100;
    check_eq("t4_lose", 32'(state_out), 32'(C_LOSE));
    frame_ticks(30);
    pulse_start();
    check_eq("t4_title", 32'(state_out), 32'(C_TITLE));

    // Test 5: the watchdog fires in PLAYER and the timeout flag sticks.
    pulse_start();
    frame_ticks(1799);
    check_eq("t5_player_1799", 32'(state_out), 32'(C_PLAYER));
    check_eq("t5_no_timeout", 32'(timeout_out), 32'd0);
    frame_ticks(1);
    check_eq("t5_gap_pe", 32'(state_out), 32'(C_GAP_PE));
    check_eq("t5_timeout", 32'(timeout_out), 32'd1);
    enemy_hp_in = 11'd0;
    frame_ticks(30);
    check_eq("t5_win", 32'(state_out), 32'(C_WIN));
    frame_ticks(30);
    pulse_start();
    check_eq("t5_title", 32'(state_out), 32'(C_TITLE));
    check_eq("t5_timeout_sticky", 32'(timeout_out), 32'd1);
    enemy_hp_in = 11'd50;
    pulse_start();
    check_eq("t5_timeout_clear", 32'(timeout_out), 32'd0);

    // A dead soul during GAP_EP also forces LOSE.
    finish_player();
    frame_ticks(30);
    enemy_finished_in = 1'b1;
    step();
    enemy_finished_in = 1'b0;
    check_eq("gap_ep_entry", 32'(state_out), 32'(C_GAP_EP));
    soul_hp_in = 8'd0;
    step();
    soul_hp_in = 8'd100;
    check_eq("gap_ep_lose", 32'(state_out), 32'(C_LOSE));
    frame_ticks(30);
    pulse_start();

    // Test 6: an asynchronous reset in the middle of ENEMY.
    pulse_start();
    finish_player();
    frame_ticks(30);
    check_eq("t6_enemy", 32'(state_out), 32'(C_ENEMY));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("t6_async_state", 32'(state_out), 32'(C_TITLE));
    check_eq("t6_async_turn", 32'(turn_count_out), 32'd0);
    check_eq("t6_async_phase", 32'(phase_start_out), 32'd0);
    check_eq("t6_async_timeout", 32'(timeout_out), 32'd0);
    step();
    rst = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
